// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: rebuilds N_CH parallel channels from a time-multiplexed word stream.
// A hunt/run FSM locks onto in_sync, beats are collected in a shadow frame, and a
// completed frame is copied to out_data one cycle after its last slot arrives.
module tdm_demux_rx #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [W-1:0]                      in_data,
    input  logic                              in_sync,
    output logic [N_CH*W-1:0]                 out_data,
    output logic                              frame_valid,
    output logic [$clog2(N_CH)-1:0]           slot_idx,
    output logic                              locked,
    output logic                              sync_err
);

    localparam int unsigned SW   = $clog2(N_CH);
    localparam int unsigned DW   = N_CH * W;
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   slot_idx_q, slot_idx_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            frame_valid_q, frame_valid_d;
    logic            sync_err_q, sync_err_d;
    logic            locked_q, locked_d;
    logic            pend_q, pend_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter RUN on a sync beat, fall back to HUNT on a missing sync at slot 0
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            unique case (state_q)
                HUNT: if (in_sync) state_d = RUN;
                RUN:  if (!in_sync && (slot_idx_q == '0)) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // Outputs and datapath: slot counter, shadow fill, deferred publish of a full frame
    always_comb begin
        slot_idx_d    = slot_idx_q;
        shadow_d      = shadow_q;
        out_data_d    = out_data_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        pend_d        = 1'b0;
        locked_d      = (state_d == RUN);

        // Shadow already holds the last slot; a new slot-0 write this cycle cannot disturb it
        if (pend_q) begin
            out_data_d    = shadow_q;
            frame_valid_d = 1'b1;
        end

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sync) begin
                        shadow_d[0 +: W] = in_data;
                        slot_idx_d       = SW'(1);
                    end
                end
                RUN: begin
                    if (in_sync) begin
                        // Early sync drops the partial frame; the beat restarts at slot 0
                        if (slot_idx_q != '0) sync_err_d = 1'b1;
                        shadow_d[0 +: W] = in_data;
                        slot_idx_d       = SW'(1);
                    end else if (slot_idx_q == '0) begin
                        sync_err_d = 1'b1;
                    end else begin
                        for (int unsigned k = 1; k < N_CH; k++) begin
                            if (slot_idx_q == SW'(k)) shadow_d[k*W +: W] = in_data;
                        end
                        if (slot_idx_q == LAST) begin
                            slot_idx_d = '0;
                            pend_d     = 1'b1;
                        end else begin
                            slot_idx_d = SW'(slot_idx_q + SW'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_idx_q    <= '0;
            shadow_q      <= '0;
            out_data_q    <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            slot_idx_q    <= slot_idx_d;
            shadow_q      <= shadow_d;
            out_data_q    <= out_data_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
            pend_q        <= pend_d;
        end
    end

    assign out_data    = out_data_q;
    assign frame_valid = frame_valid_q;
    assign slot_idx    = slot_idx_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule
